// File: rtl/vga_timing_gen.sv
// vga_timing_gen: lock-gated raster timing generator producing sync, data-enable and pixel coordinates
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk_pix,
    input  logic          reset,
    input  logic          locked,
    output logic          running,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          line_start,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic          lk1, lk2;
    logic [CW-1:0] h, v;
    logic          h_end, v_end;
    logic          de_d, hs_d, vs_d, ls_d, fs_d;
    assign h_end = 32'(h) == H_TOTAL - 1;
    assign v_end = 32'(v) == V_TOTAL - 1;
    assign de_d  = lk2 && 32'(h) < H_ACTIVE && 32'(v) < V_ACTIVE;
    assign hs_d  = lk2 && 32'(h) >= H_ACTIVE + H_FP && 32'(h) < H_ACTIVE + H_FP + H_SYNC;
    assign vs_d  = lk2 && 32'(v) >= V_ACTIVE + V_FP && 32'(v) < V_ACTIVE + V_FP + V_SYNC;
    assign ls_d  = lk2 && h == '0;
    assign fs_d  = ls_d && v == '0;
    // two-flop synchronizer bringing the asynchronous lock indicator into the pixel domain
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            lk1 <= 1'b0;
            lk2 <= 1'b0;
        end else begin
            lk1 <= locked;
            lk2 <= lk1;
        end
    end
    // raster counters, held at the origin whenever lock is absent so a new lock starts a fresh frame
    always_ff @(posedge clk_pix) begin
        if (reset || !lk2) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end) v <= v_end ? '0 : v + 1'b1;
        end
    end
    // registered decode; coordinates are gated so they read zero whenever the raster is idle
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            running     <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            sx          <= '0;
            sy          <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= lk2;
            de          <= de_d;
            hsync       <= hs_d ? H_POL : ~H_POL;
            vsync       <= vs_d ? V_POL : ~V_POL;
            sx          <= lk2 ? h : '0;
            sy          <= lk2 ? v : '0;
            line_start  <= ls_d;
            frame_start <= fs_d;
        end
    end
endmodule
